// File: rtl/ahb_vga_wrbuf.sv
// AHB-Lite write buffer for the VGA subsystem: queues console and image
// writes in an in-order FIFO and drains them to the sinks.
module ahb_vga_wrbuf #(
   parameter int FIFO_DEPTH = 8,
   parameter int PIX_W      = 8,
   parameter int IMG_AW     = 14,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic [31:0]       HRDATA,
   output logic              HREADYOUT,
   input  logic              console_busy,
   output logic              con_we,
   output logic [7:0]        con_data,
   output logic              img_we,
   output logic [IMG_AW-1:0] img_addr,
   output logic [PIX_W-1:0]  img_data,
   output logic [LVL_W-1:0]  fifo_level
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int DW = (PIX_W > 8) ? PIX_W : 8;

   typedef enum logic [1:0] {T_CON, T_STAT, T_IMG, T_NONE} tgt_e;

   typedef struct packed {
      logic              con;
      logic [IMG_AW-1:0] addr;
      logic [DW-1:0]     data;
   } ent_t;

   logic              ap_valid_q, ap_valid_d;
   logic              ap_write_q, ap_write_d;
   tgt_e              ap_tgt_q, ap_tgt_d;
   logic [IMG_AW-1:0] ap_addr_q, ap_addr_d;

   ent_t              mem_q [FIFO_DEPTH];
   ent_t              mem_d [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   logic              con_we_q, con_we_d;
   logic [7:0]        con_data_q, con_data_d;
   logic              img_we_q, img_we_d;
   logic [IMG_AW-1:0] img_addr_q, img_addr_d;
   logic [PIX_W-1:0]  img_data_q, img_data_d;

   tgt_e              dec_tgt;
   logic              full, empty;
   logic              dp_buf_wr;
   logic              push, pop;
   ent_t              head, push_ent;
   logic [31:0]       status_w;
   logic              unused_bits;

   assign unused_bits = ^{HADDR, HWDATA};

   always_comb begin
      dec_tgt = T_NONE;
      unique case (1'b1)
         HADDR[23]:                              dec_tgt = T_IMG;
         (!HADDR[23] && HADDR[22:2] == 21'd0):   dec_tgt = T_CON;
         (!HADDR[23] && HADDR[22:2] == 21'd1):   dec_tgt = T_STAT;
         default:                                dec_tgt = T_NONE;
      endcase
   end

   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty = (level_q == '0);

   assign dp_buf_wr = ap_valid_q & ap_write_q &
                      ((ap_tgt_q == T_CON) | (ap_tgt_q == T_IMG));

   // Stall follows the registered full flag only, so a same-cycle pop
   // releases the bus one cycle later.
   assign HREADYOUT = ~(dp_buf_wr & full);
   assign push      = dp_buf_wr & ~full;

   assign head = mem_q[rd_ptr_q];
   assign pop  = ~empty & ~(head.con & console_busy);

   always_comb begin
      push_ent      = '0;
      push_ent.con  = (ap_tgt_q == T_CON);
      push_ent.addr = ap_addr_q;
      push_ent.data = HWDATA[DW-1:0];
   end

   always_comb begin
      status_w              = '0;
      status_w[0]           = empty;
      status_w[1]           = full;
      status_w[8 +: LVL_W]  = level_q;
      HRDATA = '0;
      if (ap_valid_q && !ap_write_q && ap_tgt_q == T_STAT) begin
         HRDATA = status_w;
      end
   end

   always_comb begin
      ap_valid_d = ap_valid_q;
      ap_write_d = ap_write_q;
      ap_tgt_d   = ap_tgt_q;
      ap_addr_d  = ap_addr_q;
      if (HREADY) begin
         ap_valid_d = HSEL & HTRANS[1];
         ap_write_d = HWRITE;
         ap_tgt_d   = dec_tgt;
         ap_addr_d  = HADDR[IMG_AW+1:2];
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_ent;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   always_comb begin
      con_we_d   = pop & head.con;
      img_we_d   = pop & ~head.con;
      con_data_d = con_data_q;
      img_addr_d = img_addr_q;
      img_data_d = img_data_q;
      if (con_we_d) begin
         con_data_d = head.data[7:0];
      end
      if (img_we_d) begin
         img_addr_d = head.addr;
         img_data_d = head.data[PIX_W-1:0];
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         ap_valid_q <= 1'b0;
         ap_write_q <= 1'b0;
         ap_tgt_q   <= T_NONE;
         ap_addr_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         con_we_q   <= 1'b0;
         con_data_q <= '0;
         img_we_q   <= 1'b0;
         img_addr_q <= '0;
         img_data_q <= '0;
      end else begin
         ap_valid_q <= ap_valid_d;
         ap_write_q <= ap_write_d;
         ap_tgt_q   <= ap_tgt_d;
         ap_addr_q  <= ap_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         con_we_q   <= con_we_d;
         con_data_q <= con_data_d;
         img_we_q   <= img_we_d;
         img_addr_q <= img_addr_d;
         img_data_q <= img_data_d;
      end
   end

   // Storage needs no reset: entries are only read while the level is non-zero.
   always_ff @(posedge HCLK) begin
      mem_q <= mem_d;
   end

   assign con_we     = con_we_q;
   assign con_data   = con_data_q;
   assign img_we     = img_we_q;
   assign img_addr   = img_addr_q;
   assign img_data   = img_data_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_ahb_vga_wrbuf.sv
// Bench for ahb_vga_wrbuf: queue-level reference model compared every
// cycle, directed scenarios and a randomized bus/back-pressure phase.
module tb_ahb_vga_wrbuf;
   localparam int DEPTH  = 8;
   localparam int PIX_W  = 8;
   localparam int IMG_AW = 14;
   localparam int LVL_W  = 4;

   logic              HCLK = 1'b0;
   logic              HRESETn = 1'b0;
   logic              HSEL = 1'b0;
   logic [31:0]       HADDR = '0;
   logic [1:0]        HTRANS = '0;
   logic              HWRITE = 1'b0;
   logic [31:0]       HWDATA = '0;
   wire               HREADY;
   logic [31:0]       HRDATA;
   logic              HREADYOUT;
   logic              console_busy = 1'b0;
   logic              con_we;
   logic [7:0]        con_data;
   logic              img_we;
   logic [IMG_AW-1:0] img_addr;
   logic [PIX_W-1:0]  img_data;
   logic [LVL_W-1:0]  fifo_level;

   assign HREADY = HREADYOUT;

   ahb_vga_wrbuf #(
      .FIFO_DEPTH(DEPTH), .PIX_W(PIX_W), .IMG_AW(IMG_AW)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .console_busy(console_busy), .con_we(con_we), .con_data(con_data),
      .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
      .fifo_level(fifo_level)
   );

   always #5 HCLK = ~HCLK;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          con;
      int unsigned addr;
      int unsigned data;
   } ment_t;

   ment_t       mq[$];
   bit          m_init = 0;
   bit          m_dp_v = 0;
   bit          m_dp_w = 0;
   int          m_dp_k = 3;
   int unsigned m_dp_a = 0;
   bit          e_con_we = 0, e_img_we = 0;
   int unsigned e_con_data = 0, e_img_addr = 0, e_img_data = 0;
   bit          m_rdy, m_push;
   ment_t       m_h, m_n;

   // 0 console, 1 status, 2 image, 3 other
   function automatic int kind(logic [31:0] a);
      if (a[23]) return 2;
      if (a[22:2] == 21'd0) return 0;
      if (a[22:2] == 21'd1) return 1;
      return 3;
   endfunction

   function automatic bit m_ready();
      return !(m_dp_v && m_dp_w && (m_dp_k == 0 || m_dp_k == 2) &&
               mq.size() == DEPTH);
   endfunction

   function automatic logic [31:0] m_rdata();
      int n;
      n = mq.size();
      if (m_dp_v && !m_dp_w && m_dp_k == 1)
         return 32'(n * 256 + (n == DEPTH ? 2 : 0) + (n == 0 ? 1 : 0));
      return 32'd0;
   endfunction

   always @(posedge HCLK) begin
      cyc++;
      if (!HRESETn) begin
         mq.delete();
         m_dp_v = 0;
         e_con_we = 0; e_img_we = 0;
         e_con_data = 0; e_img_addr = 0; e_img_data = 0;
         m_init = 1;
      end else if (m_init) begin
         m_rdy  = m_ready();
         m_push = m_dp_v && m_dp_w && (m_dp_k == 0 || m_dp_k == 2) && m_rdy;
         e_con_we = 0;
         e_img_we = 0;
         if (mq.size() > 0 && !(mq[0].con && console_busy)) begin
            m_h = mq.pop_front();
            if (m_h.con) begin
               e_con_we = 1; e_con_data = m_h.data;
            end else begin
               e_img_we = 1; e_img_addr = m_h.addr; e_img_data = m_h.data;
            end
         end
         if (m_push) begin
            m_n.con  = (m_dp_k == 0);
            m_n.addr = m_dp_a;
            m_n.data = m_n.con ? 32'(HWDATA[7:0]) : 32'(HWDATA[PIX_W-1:0]);
            mq.push_back(m_n);
         end
         if (m_rdy) begin
            m_dp_v = HSEL && HTRANS[1];
            m_dp_w = HWRITE;
            m_dp_k = kind(HADDR);
            m_dp_a = 32'(HADDR[IMG_AW+1:2]);
         end
      end
   end

   // ---------------- per-cycle compare + strobe log ----------------
   typedef struct {
      int          k;
      int unsigned a;
      int unsigned d;
      int          c;
   } log_t;

   log_t slog[$];
   int   lvl_max = 0;

   always @(negedge HCLK) begin
      if (m_init) begin
         chk("hreadyout", 32'(HREADYOUT), 32'(m_ready()));
         chk("hrdata", HRDATA, m_rdata());
         chk("con_we", 32'(con_we), 32'(e_con_we));
         chk("img_we", 32'(img_we), 32'(e_img_we));
         chk("con_data", 32'(con_data), e_con_data);
         chk("img_addr", 32'(img_addr), e_img_addr);
         chk("img_data", 32'(img_data), e_img_data);
         chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
         if (con_we) slog.push_back('{0, 0, 32'(con_data), cyc});
         if (img_we) slog.push_back('{2, 32'(img_addr), 32'(img_data), cyc});
         if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      end
   end

   // ---------------- bus driver ----------------
   typedef struct {
      bit          act;
      logic [1:0]  trans;
      logic [31:0] a;
      bit          w;
      logic [31:0] d;
   } op_t;

   op_t         ops[$];
   int          waits = 0;
   int          wr_done = 0;
   int          first_stall_done = -1;
   logic [31:0] last_rd = '0;
   int          last_push_cyc = 0;

   task automatic add_op(logic [31:0] a, bit w, logic [31:0] d);
      ops.push_back('{1'b1, 2'b10, a, w, d});
   endtask

   task automatic run_ops();
      bit          dpv = 0;
      bit          dpw = 0;
      logic [31:0] dpd = '0;
      bit          rdy;
      int          stall = 0;
      op_t         cur;
      while (ops.size() > 0 || dpv) begin
         if (ops.size() > 0) begin
            cur    = ops[0];
            HSEL   = cur.act;
            HTRANS = cur.act ? cur.trans : 2'b00;
            HADDR  = cur.a;
            HWRITE = cur.w;
         end else begin
            HSEL = 0; HTRANS = 2'b00;
         end
         HWDATA = (dpv && dpw) ? dpd : $urandom();
         @(negedge HCLK);
         rdy = HREADYOUT;
         if (dpv && dpw && !rdy) begin
            if (waits == 0) first_stall_done = wr_done;
            waits++;
         end
         if (dpv && dpw && rdy) begin
            wr_done++;
            last_push_cyc = cyc + 1;
         end
         if (dpv && !dpw && rdy) last_rd = HRDATA;
         @(posedge HCLK); #1;
         if (rdy) begin
            stall = 0;
            if (ops.size() > 0) begin
               cur = ops.pop_front();
               dpv = cur.act && cur.trans[1];
               dpw = cur.w;
               dpd = cur.d;
            end else dpv = 0;
         end else begin
            stall++;
            if (stall > 200) begin
               total++;
               $display("FAIL drv_timeout: got stall %0d expected <=200", stall);
               ops.delete();
               HSEL = 0; HTRANS = 2'b00;
               return;
            end
         end
      end
      HSEL = 0; HTRANS = 2'b00;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   bit rnd_run = 0;
   int w0;
   bit ok;

   initial begin
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // reset state, status read
      add_op(32'h0000_0004, 0, 0);
      run_ops();
      chk("reset_status", last_rd, 32'h1);
      chk("reset_no_strobe", 32'(slog.size()), 0);

      // single image write latency
      slog.delete();
      add_op(32'h0080_0010, 1, 32'hA5);
      run_ops();
      idle(3);
      chk("img1_count", 32'(slog.size()), 1);
      if (slog.size() == 1) begin
         chk("img1_kind", 32'(slog[0].k), 2);
         chk("img1_addr", slog[0].a, 4);
         chk("img1_data", slog[0].d, 32'hA5);
         chk("img1_lat", 32'(slog[0].c), 32'(last_push_cyc + 1));
      end
      chk("img1_level", 32'(fifo_level), 0);

      // console back-pressure
      slog.delete();
      waits = 0; wr_done = 0; first_stall_done = -1;
      console_busy = 1;
      for (int i = 0; i < 9; i++) add_op(32'h0, 1, 32'h61 + 32'(i));
      add_op(32'h4, 0, 0);
      fork
         run_ops();
         begin
            for (int t = 0; t < 100 && waits == 0; t++) @(posedge HCLK);
            idle(3);
            console_busy = 0;
         end
      join
      idle(15);
      chk("bp_stalled", 32'(waits > 0), 1);
      chk("bp_free_writes", 32'(first_stall_done), 8);
      chk("bp_count", 32'(slog.size()), 9);
      ok = 1;
      for (int i = 0; i < slog.size() && i < 9; i++)
         if (slog[i].k != 0 || slog[i].d != 32'h61 + 32'(i)) ok = 0;
      chk("bp_order", 32'(ok), 1);

      // ordering under busy
      slog.delete();
      console_busy = 1;
      add_op(32'h0, 1, 32'h58);
      add_op(32'h0080_0000, 1, 32'h11);
      run_ops();
      idle(5);
      chk("ord_blocked", 32'(slog.size()), 0);
      console_busy = 0;
      idle(5);
      chk("ord_count", 32'(slog.size()), 2);
      if (slog.size() == 2) begin
         chk("ord_first", 32'(slog[0].k) << 8 | slog[0].d, 32'h058);
         chk("ord_second", 32'(slog[1].k) << 8 | slog[1].d, 32'h211);
         chk("ord_seq", 32'(slog[1].c > slog[0].c), 1);
      end

      // throughput with pointer wrap
      slog.delete();
      lvl_max = 0;
      w0 = waits;
      for (int i = 0; i < 16; i++)
         add_op(32'h0080_0000 + 32'(4 * i), 1, 32'(i * 7 + 3));
      run_ops();
      idle(4);
      chk("tp_waits", 32'(waits - w0), 0);
      chk("tp_count", 32'(slog.size()), 16);
      chk("tp_lvl_max", 32'(lvl_max <= 1), 1);
      ok = 1;
      for (int i = 0; i < slog.size(); i++) begin
         if (slog[i].k != 2 || slog[i].a != 32'(i) ||
             slog[i].d != 32'(i * 7 + 3)) ok = 0;
         if (i > 0 && slog[i].c != slog[i-1].c + 1) ok = 0;
      end
      chk("tp_stream", 32'(ok), 1);

      // reset mid-drain
      console_busy = 1;
      for (int i = 0; i < 5; i++) add_op(32'h0, 1, 32'h30 + 32'(i));
      run_ops();
      @(negedge HCLK);
      chk("rst_fill", 32'(fifo_level), 5);
      @(posedge HCLK); #1 HRESETn = 1'b0;
      @(posedge HCLK); #1 HRESETn = 1'b1;
      console_busy = 0;
      slog.delete();
      idle(8);
      chk("rst_no_strobe", 32'(slog.size()), 0);
      chk("rst_level", 32'(fifo_level), 0);
      add_op(32'h0, 1, 32'h5A);
      run_ops();
      idle(4);
      chk("rst_after_cnt", 32'(slog.size()), 1);
      if (slog.size() == 1) chk("rst_after_dat", slog[0].d, 32'h5A);

      // randomized traffic with random console back-pressure
      rnd_run = 1;
      fork
         while (rnd_run) begin
            @(posedge HCLK); #1;
            console_busy = ($urandom_range(0, 3) == 0);
         end
      join_none
      for (int i = 0; i < 400; i++) begin
         op_t o;
         int  sel;
         o.act   = ($urandom_range(0, 4) != 0);
         o.trans = $urandom_range(0, 1) ? 2'b11 : 2'b10;
         o.w     = ($urandom_range(0, 3) != 0);
         o.d     = $urandom();
         sel     = $urandom_range(0, 4);
         o.a     = {8'($urandom()), 24'h0};
         case (sel)
            0:       o.a[23:0] = 24'h0;
            1:       o.a[23:0] = 24'h4;
            2:       o.a[23:0] = 24'h8 + 24'(4 * $urandom_range(0, 1000));
            default: o.a[23:0] = {1'b1, 23'($urandom())};
         endcase
         ops.push_back(o);
      end
      run_ops();
      rnd_run = 0;
      idle(2);
      console_busy = 0;
      idle(20);
      chk("rnd_drained", 32'(fifo_level), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ahb_vga_wrbuf.md
Name: ahb_vga_wrbuf

Overview:
Parametrised AHB-Lite write-buffer front end for the VGA subsystem. It decouples CPU writes from display back-pressure: writes are queued in an in-order FIFO and drained to the console and image-buffer sinks. The bus stalls only when the FIFO is full, never on console scroll. A status word gives software the fill level and the empty/full flags.

Parameters:
FIFO_DEPTH, 8, number of queued writes; power of two, >= 2
PIX_W, 8, image pixel width in bits, 1..24
IMG_AW, 14, image word-address width, 1..21
LVL_W, $clog2(FIFO_DEPTH+1), fill-level width (derived; do not override)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  reset, synchronous, active-low
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  transfer type; bit1 = NONSEQ/SEQ
HWRITE  in  1  1 = write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
console_busy  in  1  console sink cannot accept (scrolling)
con_we  out  1  console write strobe
con_data  out  8  console character
img_we  out  1  image write strobe
img_addr  out  IMG_AW  image word address
img_data  out  PIX_W  image pixel
fifo_level  out  LVL_W  current occupancy

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low on HRESETn; all state is sampled on the HCLK rising edge.
  - Reset clears the FIFO (level 0) and the captured address phase.
  - Reset values: con_we=0, img_we=0, con_data=0, img_addr=0, img_data=0, HRDATA=0, HREADYOUT=1, fifo_level=0.
  - Reset mid-transfer discards the queued writes and any pending data phase.
- Address map, decoded on HADDR[23:0]:
  - Word 0x000000: console data. Write only; reads return 0.
  - Word 0x000004: STATUS. Read only; writes are accepted with OKAY and dropped.
  - HADDR[23]=1: image region. img_addr = HADDR[IMG_AW+1:2]; pixel = HWDATA[PIX_W-1:0].
  - All other offsets: writes dropped, reads 0.
- STATUS layout: bit0 = empty, bit1 = full, bits[8+LVL_W-1:8] = level, all other bits 0.
- Address phase: captured when HSEL & HREADY & HTRANS[1]. Otherwise the capture register's valid bit clears while HREADY=1.
- Write data phase, for a console or image target:
  - HREADYOUT = ~full.
  - The entry {target, addr, data} is pushed on the edge where HREADYOUT=1.
  - Full is the registered flag. A pop in the same cycle does not release the stall; the stall ends on the next cycle.
- Dropped writes and reads complete with zero wait states.
  - HRDATA is driven combinationally from the registered status during the data phase and is 0 otherwise.
- Drain: the head entry is popped when the FIFO is non-empty, unless the head is a console entry and console_busy=1.
  - A console head blocks the entries behind it; strict ordering is kept.
  - The image head ignores console_busy.
- Output timing:
  - On a pop, the matching strobe and its data/address are registered and high for exactly one cycle.
  - The other strobe stays 0. Data/address outputs hold their last value when the strobe is low.
  - Latency: with the FIFO empty, a push at edge N produces a strobe visible from edge N+1 to edge N+2. Back-to-back pops give consecutive strobe cycles.
- Simultaneous push and pop: occupancy is unchanged; pointers wrap modulo FIFO_DEPTH.
  - Level never exceeds FIFO_DEPTH and never underflows; pop on empty is impossible by construction.
- No error responses are generated; HRESP is not provided and the fabric ties it to OKAY.

Test Plan:
- Reset and read: pulse HRESETn low for 2 cycles, then read 0x004 -> HRDATA=0x00000001, HREADYOUT=1, both strobes 0.
- Single image write: with the FIFO empty, write 0x800010 data 0xA5 (push at edge N) -> img_we high from N+1 for 1 cycle; img_addr=4, img_data=0xA5; fifo_level returns to 0.
- Console back-pressure: hold console_busy=1 and issue 9 console writes (depth 8).
  - Expect: 8 complete with zero waits; the 9th stalls with HREADYOUT=0.
  - Status read is blocked behind the stall. After console_busy drops, 9 con_we pulses occur in issue order and the stall releases the cycle after the first pop.
- Ordering under busy: queue console 'X', then image 0x800000/0x11, with console_busy=1 -> no img_we until busy drops; then con_we precedes img_we.
- Throughput: 16 back-to-back image writes with console_busy=0 -> no wait states; 16 consecutive img_we cycles with fifo_level <= 1; pointer wrap exercised.
- Reset mid-drain: fill 5 entries, assert HRESETn=0 for 1 cycle -> no further strobes, fifo_level=0, and the next write is serviced normally.
